// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg
// Shared definitions for the convolution MAC engine and its helpers:
//   - FSM state encoding
//   - register-file address map (pixels, weights, bias)
//   - constant-evaluable clog2 helper
package conv_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Pixels occupy 0..N-1, weights N..2N-1, bias sits at 2N.
    localparam int PIX_BASE = 0;

    function automatic int wgt_base(input int n);
        return n;
    endfunction

    function automatic int bias_addr(input int n);
        return 2 * n;
    endfunction

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_engine_if.sv
// conv_mac_engine_if
// Write port, start/result handshake and status of the convolution engine.
//   master : window loader / controller side (drives writes and start)
//   slave  : engine side (drives busy, result and status pulses)
interface conv_mac_engine_if #(
    parameter int DW = 16,
    parameter int AW = 5
);
    logic                 we;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] data_in;
    logic                 start;
    logic                 relu_en;
    logic                 busy;
    logic                 out_valid;
    logic signed [DW-1:0] out_pix;
    logic                 sat;
    logic                 wr_drop;

    modport master (
        output we, addr, data_in, start, relu_en,
        input  busy, out_valid, out_pix, sat, wr_drop
    );

    modport slave (
        input  we, addr, data_in, start, relu_en,
        output busy, out_valid, out_pix, sat, wr_drop
    );
endinterface

// File: rtl/conv_sat_round.sv
// conv_sat_round
// Combinational post-processing of a wide signed accumulator:
// round half up, arithmetic shift by FRAC, saturate to DW bits, optional ReLU.
//   i_acc     : signed accumulator, ACCW bits
//   i_relu_en : clamp negative results to zero
//   o_value   : signed DW-bit result
//   o_sat     : clipping occurred (evaluated before ReLU)
module conv_sat_round #(
    parameter int ACCW = 40,
    parameter int DW   = 16,
    parameter int FRAC = 0
) (
    input  logic signed [ACCW-1:0] i_acc,
    input  logic                   i_relu_en,
    output logic signed [DW-1:0]   o_value,
    output logic                   o_sat
);
    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACCW-1:0] w_shifted;
    logic signed [DW-1:0]   w_clip;

    generate
        if (FRAC > 0) begin : g_round
            logic signed [ACCW-1:0] w_rounded;
            // Accumulator headroom keeps the rounding add from wrapping.
            assign w_rounded = i_acc + (ACCW'(1) << (FRAC - 1));
            assign w_shifted = w_rounded >>> FRAC;
        end else begin : g_noround
            assign w_shifted = i_acc;
        end
    endgenerate

    always_comb begin
        o_sat  = 1'b0;
        w_clip = w_shifted[DW-1:0];
        if (w_shifted > MAXV) begin
            w_clip = MAXV[DW-1:0];
            o_sat  = 1'b1;
        end else if (w_shifted < MINV) begin
            w_clip = MINV[DW-1:0];
            o_sat  = 1'b1;
        end
        o_value = (i_relu_en && w_clip[DW-1]) ? '0 : w_clip;
    end

endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine
// K x K convolution tap engine. A local register file holds one pixel
// window, one kernel and a bias; on start a single signed multiplier walks
// all taps, then the sum is rounded/saturated/ReLU'd into one output pixel.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of conv_mac_engine_if (writes, start, result)
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start; register file writable
// ST_RUN  | one tap multiplied and accumulated per cycle
// ST_DONE | post-process accumulator, pulse out_valid
module conv_mac_engine
    import conv_mac_pkg::*;
#(
    parameter int DW    = 16,
    parameter int KSIZE = 3,
    parameter int ACCW  = 2 * DW + 8,
    parameter int FRAC  = 0,
    parameter int AW    = clog2(2 * KSIZE * KSIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    conv_mac_engine_if.slave   bus
);
    localparam int N    = KSIZE * KSIZE;
    localparam int NREG = 2 * N + 1;
    localparam int IW   = (clog2(N) > 0) ? clog2(N) : 1;
    localparam int SW   = clog2(NREG);
    localparam logic [AW-1:0] LAST_ADDR = AW'(bias_addr(N));
    localparam logic [SW-1:0] BIAS_SEL  = SW'(bias_addr(N));

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [DW-1:0]   r_rf [NREG];
    logic signed [ACCW-1:0] r_acc;
    logic [IW-1:0]          r_idx;
    logic                   r_relu;
    logic                   r_out_valid;
    logic signed [DW-1:0]   r_out_pix;
    logic                   r_sat;
    logic                   r_wr_drop;

    logic                   w_busy;
    logic                   w_accept_start;
    logic                   w_last_tap;
    logic                   w_addr_bad;
    logic                   w_wr_ok;
    logic                   w_wr_drop_set;
    logic [SW-1:0]          w_wr_sel;
    logic [SW-1:0]          w_pix_sel;
    logic [SW-1:0]          w_wgt_sel;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_bias_ext;
    logic signed [DW-1:0]   w_post_value;
    logic                   w_post_sat;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last_tap) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy         = (r_state != ST_IDLE);
        w_accept_start = (r_state == ST_IDLE) && bus.start;
        w_last_tap     = (r_idx == IW'(N - 1));
        w_addr_bad     = (bus.addr > LAST_ADDR);
        w_wr_ok        = bus.we && !w_busy && !w_addr_bad;
        w_wr_drop_set  = bus.we && (w_busy || w_addr_bad);
    end

    assign w_wr_sel   = SW'(bus.addr);
    assign w_pix_sel  = SW'(PIX_BASE) + SW'(r_idx);
    assign w_wgt_sel  = SW'(wgt_base(N)) + SW'(r_idx);
    // Operand reads are live; writes are blocked while busy so they hold still.
    assign w_prod     = r_rf[w_pix_sel] * r_rf[w_wgt_sel];
    assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_bias_ext = {{(ACCW-DW){r_rf[BIAS_SEL][DW-1]}}, r_rf[BIAS_SEL]};

    conv_sat_round #(
        .ACCW (ACCW),
        .DW   (DW),
        .FRAC (FRAC)
    ) u_sat_round (
        .i_acc     (r_acc),
        .i_relu_en (r_relu),
        .o_value   (w_post_value),
        .o_sat     (w_post_sat)
    );

    // Datapath and register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_idx       <= '0;
            r_relu      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_sat       <= 1'b0;
            r_wr_drop   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_wr_drop   <= w_wr_drop_set;
            // A write in the start cycle lands after the bias snapshot below.
            if (w_wr_ok) begin
                r_rf[w_wr_sel] <= bus.data_in;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_start) begin
                        r_acc  <= w_bias_ext;
                        r_idx  <= '0;
                        r_relu <= bus.relu_en;
                    end
                end
                ST_RUN: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (!w_last_tap) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_out_pix   <= w_post_value;
                    r_sat       <= w_post_sat;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pix   = r_out_pix;
    assign bus.sat       = r_sat;
    assign bus.wr_drop   = r_wr_drop;

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine
// Directed bench: two engines (FRAC=0 and FRAC=1) share one stimulus stream.
module tb_conv_mac_engine;
    localparam int DW = 16;
    localparam int AW = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 we = 1'b0;
    logic [AW-1:0]        addr = '0;
    logic signed [DW-1:0] data_in = '0;
    logic                 start = 1'b0;
    logic                 relu_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    conv_mac_engine_if #(.DW(DW), .AW(AW)) if0 ();
    conv_mac_engine_if #(.DW(DW), .AW(AW)) if1 ();

    assign if0.we = we;      assign if1.we = we;
    assign if0.addr = addr;  assign if1.addr = addr;
    assign if0.data_in = data_in; assign if1.data_in = data_in;
    assign if0.start = start;     assign if1.start = start;
    assign if0.relu_en = relu_en; assign if1.relu_en = relu_en;

    conv_mac_engine #(.DW(DW), .KSIZE(3), .FRAC(0)) dut (
        .clk (clk), .rst (rst), .bus (if0.slave)
    );
    conv_mac_engine #(.DW(DW), .KSIZE(3), .FRAC(1)) dut_f1 (
        .clk (clk), .rst (rst), .bus (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input int a, input int d, output int drop);
        @(negedge clk);
        we = 1'b1; addr = AW'(a); data_in = DW'(d);
        @(posedge clk); #1;
        drop = int'(if0.wr_drop);
        we = 1'b0;
    endtask

    task automatic load(input int p[9], input int w[9], input int b);
        int d;
        for (int i = 0; i < 9; i++) wr(i, p[i], d);
        for (int i = 0; i < 9; i++) wr(9 + i, w[i], d);
        wr(18, b, d);
    endtask

    // Runs one computation. inj>0 pulses start and a write of 99 to addr 0
    // before edge E<inj>; wr_st performs a write alongside start.
    task automatic run(input bit relu, input int inj, input bit wr_st,
                       input int wa, input int wd,
                       output int lat, output int pix0, output int sat0,
                       output int pix1, output int drops);
        lat = 0; drops = 0;
        @(negedge clk);
        start = 1'b1; relu_en = relu;
        if (wr_st) begin we = 1'b1; addr = AW'(wa); data_in = DW'(wd); end
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == inj) begin
                start = 1'b1; we = 1'b1; addr = '0; data_in = 16'sd99;
            end else begin
                start = 1'b0; we = 1'b0;
            end
            @(posedge clk); #1;
            lat = k;
            if (if0.wr_drop) drops++;
            if (if0.out_valid) break;
        end
        if (!if0.out_valid) lat = -1;
        pix0 = int'(if0.out_pix);
        sat0 = int'(if0.sat);
        pix1 = int'(if1.out_pix);
        @(negedge clk);
        start = 1'b0; we = 1'b0;
    endtask

    int lat, p0, s0, p1, dr, drop, seen;
    int pa[9], wa[9];

    initial begin
        #12;
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_valid", int'(if0.out_valid), 0);
        chk("rst_pix", int'(if0.out_pix), 0);
        chk("rst_sat", int'(if0.sat), 0);
        chk("rst_drop", int'(if0.wr_drop), 0);
        @(negedge clk); rst = 1'b0;

        // Basic three-tap sum: 1*2 + 2*3 - 3*4 = -4
        pa = '{1, 2, -3, 0, 0, 0, 0, 0, 0};
        wa = '{2, 3, 4, 0, 0, 0, 0, 0, 0};
        load(pa, wa, 0);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("basic_lat", lat, 10);
        chk("basic_pix", p0, -4);
        chk("basic_sat", s0, 0);
        @(posedge clk); #1;
        chk("valid_pulse", int'(if0.out_valid), 0);
        chk("pix_held", int'(if0.out_pix), -4);
        run(1, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("relu_pix", p0, 0);
        chk("relu_sat", s0, 0);

        // Positive and negative saturation
        pa = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        wa = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        load(pa, wa, 0);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("satp_pix", p0, 32767);
        chk("satp_sat", s0, 1);
        pa = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        load(pa, wa, 0);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("satn_pix", p0, -32768);
        chk("satn_sat", s0, 1);
        run(1, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("satn_relu_pix", p0, 0);
        chk("satn_relu_sat", s0, 1);

        // Bias plus one tap: 100 + 5*7 = 135
        pa = '{5, 0, 0, 0, 0, 0, 0, 0, 0};
        wa = '{7, 0, 0, 0, 0, 0, 0, 0, 0};
        load(pa, wa, 100);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("bias_pix", p0, 135);

        // FRAC=1 rounding: 3*1 = 3 -> (3+1)>>1 = 2
        pa = '{3, 0, 0, 0, 0, 0, 0, 0, 0};
        wa = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        load(pa, wa, 0);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("frac0_pix", p0, 3);
        chk("frac1_pix", p1, 2);
        // FRAC=1, -3 -> (-3+1)>>>1 = -1
        pa = '{-3, 0, 0, 0, 0, 0, 0, 0, 0};
        load(pa, wa, 0);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("frac1_neg_pix", p1, -1);

        // Start and write while busy are both ignored
        pa = '{1, 2, -3, 0, 0, 0, 0, 0, 0};
        wa = '{2, 3, 4, 0, 0, 0, 0, 0, 0};
        load(pa, wa, 0);
        run(0, 3, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("busy_lat", lat, 10);
        chk("busy_pix", p0, -4);
        chk("busy_drops", dr, 1);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("busy_nochange", p0, -4);

        // Out-of-range and in-range writes in IDLE
        wr(19, 555, drop);
        chk("oor_drop", drop, 1);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("oor_nochange", p0, -4);
        wr(11, 4, drop);
        chk("ok_nodrop", drop, 0);
        wr(11, 4, drop);

        // Write with start: old bias used now, new bias next time
        run(0, 0, 1, 18, 1000, lat, p0, s0, p1, dr);
        chk("wrst_old", p0, -4);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("wrst_new", p0, 996);

        // Reset mid-run aborts without a result and clears the register file
        @(negedge clk); start = 1'b1; relu_en = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("abort_busy", int'(if0.busy), 0);
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (if0.out_valid) seen++; end
        @(negedge clk); rst = 1'b0;
        repeat (15) begin @(posedge clk); #1; if (if0.out_valid) seen++; end
        chk("abort_novalid", seen, 0);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("cleared_pix", p0, 0);
        load(pa, wa, 0);
        run(0, 0, 0, 0, 0, lat, p0, s0, p1, dr);
        chk("rerun_lat", lat, 10);
        chk("rerun_pix", p0, -4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
